hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Generates PC/pipeline-register enables and flushes for load-use stalls and taken branches resolved in MEM. Runs a request/ready handshake with data memory for loads and stores, freezing the pipeline while an access is outstanding. Sits beside IF/ID, ID/EX, EX/MEM and MEM/WB and drives their enable and flush inputs.

Parameters:
TIMEOUT, 15, maximum MEM_WAIT cycles without mem_ready before the error lock; legal range 1..255.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous reset, active low.
id_rs1  input  5  rs1 of the instruction in ID.
id_rs2  input  5  rs2 of the instruction in ID.
idex_memread  input  1  the instruction in EX is a load.
idex_rd  input  5  rd of the instruction in EX.
exmem_branch  input  1  taken branch in MEM (Branch already ANDed with Zero).
exmem_memread  input  1  the instruction in MEM is a load.
exmem_memwrite  input  1  the instruction in MEM is a store.
mem_ready  input  1  data memory has completed the current access this cycle.
pc_en  output  1  PC load enable.
pc_sel  output  1  1 selects the branch target (EX/MEM addr_jump); 0 selects PC+4.
ifid_en  output  1  IF/ID load enable.
pipe_en  output  1  ID/EX and EX/MEM load enable.
ifid_flush  output  1  IF/ID captures a NOP.
idex_flush  output  1  ID/EX captures a bubble (all controls 0).
exmem_flush  output  1  EX/MEM captures a bubble.
memwb_flush  output  1  MEM/WB captures a bubble.
mem_req  output  1  data-memory access request.
mem_err  output  1  sticky timeout error.
stall_cycles  output  CNT_W  count of cycles with pc_en=0, saturating.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. The state register, the wait counter (8 bit), mem_err and stall_cycles are registered. All other outputs are Mealy (combinational from state and inputs).
- While rst_n=0: state=RUN, wait counter=0, mem_err=0, stall_cycles=0.
- While rst_n=0: pc_en=0, pc_sel=0, ifid_en=0, pipe_en=0, all flushes=0, mem_req=0.
- Default in RUN with no event: pc_en=ifid_en=pipe_en=1, pc_sel=0, all flushes=0, mem_req=0.
- mem_op = exmem_memread | exmem_memwrite. In RUN, mem_req = mem_op.
- RUN, mem_op=1 and mem_ready=1: zero-latency access, no stall, state stays RUN.
- RUN, mem_op=1 and mem_ready=0: next state MEM_WAIT, wait counter cleared to 0. In this same cycle pc_en=ifid_en=pipe_en=0 and memwb_flush=1.
- MEM_WAIT: mem_req=1; pc_en=ifid_en=pipe_en=0; memwb_flush=1 unless mem_ready=1.
  - mem_ready=1: enables released this cycle, memwb_flush=0, next state RUN.
  - mem_ready=0 and wait counter = TIMEOUT-1: next state ERR. Otherwise the counter increments.
- ERR: mem_err=1, pc_en=ifid_en=pipe_en=0, memwb_flush=1, mem_req=0. Only reset exits ERR.
- Taken branch (RUN, exmem_branch=1, no memory stall this cycle): pc_en=1, pc_sel=1, ifid_flush=idex_flush=exmem_flush=1. Lasts one cycle and needs no state.
- Load-use (RUN, no memory stall, no branch):
  - Condition: idex_memread=1, idex_rd!=0, and idex_rd==id_rs1 or idex_rd==id_rs2.
  - Response: pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1. Exactly one bubble per hazard.
- Priority: memory stall/ERR > branch flush > load-use. A branch held in frozen EX/MEM is acted on the cycle the stall releases.
- A branch and a load or store are never both in MEM (decoder guarantees); no combined case is defined.
- stall_cycles increments every cycle pc_en=0 (rst_n high) and saturates at all-ones.
- An asynchronous reset during MEM_WAIT aborts the access: mem_req drops immediately and the state returns to RUN.

Test Plan:
- Reset release, no hazards → pc_en=ifid_en=pipe_en=1, all flushes=0, stall_cycles stays 0 over 10 cycles.
- idex_memread=1, idex_rd=5, id_rs2=5 for one cycle → pc_en=0, ifid_en=0, idex_flush=1 that cycle only; stall_cycles=1. Repeat with idex_rd=0 → no stall.
- exmem_branch=1 together with a load-use match → pc_sel=1, pc_en=1, ifid/idex/exmem_flush=1, no stall (branch wins).
- exmem_memread=1, mem_ready raised 3 cycles later → mem_req high 4 cycles; enables 0 for 3 cycles and 1 on the ready cycle; memwb_flush=1 for 3 cycles; stall_cycles=3.
- TIMEOUT=4, exmem_memwrite=1, mem_ready never asserted → mem_err=1 from the 6th cycle (1 RUN + 4 MEM_WAIT); enables stay 0 and mem_req=0 until reset; rst_n pulse clears mem_err.
- rst_n asserted mid-MEM_WAIT → mem_req=0 and all enables 0 immediately; after release, state is RUN and stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between hazard_ctrl and the pipeline/data-memory side.
// The master modport belongs to the sequencer; the slave modport belongs to the pipeline it drives.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic             exmem_branch;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic             mem_ready;
    logic             pc_en;
    logic             pc_sel;
    logic             ifid_en;
    logic             pipe_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  id_rs1, id_rs2, idex_memread, idex_rd, exmem_branch,
               exmem_memread, exmem_memwrite, mem_ready,
        output pc_en, pc_sel, ifid_en, pipe_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, mem_req, mem_err, stall_cycles
    );

    modport slave (
        output id_rs1, id_rs2, idex_memread, idex_rd, exmem_branch,
               exmem_memread, exmem_memwrite, mem_ready,
        input  pc_en, pc_sel, ifid_en, pipe_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, mem_req, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use bubbles, MEM-stage branch flushes and a
// data-memory request/ready handshake with timeout lock, plus a stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.master bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_op, load_use;
    logic pc_en, pc_sel, ifid_en, pipe_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_req;

    assign mem_op   = bus.exmem_memread | bus.exmem_memwrite;
    assign load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                      ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        ifid_en     = 1'b0;
        pipe_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        mem_req     = 1'b0;

        unique case (state_q)
            RUN: begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                pipe_en = 1'b1;
                mem_req = mem_op;
                if (mem_op && !bus.mem_ready) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    pipe_en     = 1'b0;
                    memwb_flush = 1'b1;
                    wait_d      = '0;
                    state_d     = MEM_WAIT;
                end else if (bus.exmem_branch) begin
                    pc_sel      = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    pipe_en = 1'b1;
                    state_d = RUN;
                end else begin
                    memwb_flush = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        mem_err_d = 1'b1;
                        state_d   = ERR;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            ERR: begin
                memwb_flush = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // Reset must silence the pipeline immediately, not just at the next edge.
        if (!rst_n) begin
            pc_en       = 1'b0;
            pc_sel      = 1'b0;
            ifid_en     = 1'b0;
            pipe_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            memwb_flush = 1'b0;
            mem_req     = 1'b0;
        end

        stall_d = (!pc_en && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.pc_sel       = pc_sel;
    assign bus.ifid_en      = ifid_en;
    assign bus.pipe_en      = pipe_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.memwb_flush  = memwb_flush;
    assign bus.mem_req      = mem_req;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cycles = stall_q;
endmodule
